// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and forwarding control for a 5-stage pipeline.
// Tracks EX/MEM/WR register usage, drives bypass selects, stalls and flushes.
module hazard_fwd_ctrl #(
  parameter int FLUSH_CYC = 1,
  parameter int REGW      = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Hold,
  input  logic            Valid_Id,
  input  logic [REGW-1:0] Rs_Id,
  input  logic [REGW-1:0] Rt_Id,
  input  logic            UseRs_Id,
  input  logic            UseRt_Id,
  input  logic [REGW-1:0] Dst_Id,
  input  logic            RegWr_Id,
  input  logic            MemToReg_Id,
  input  logic            BrTaken_Ex,
  output logic            Stall_PC_IFID,
  output logic            Bubble_IDEX,
  output logic            Flush_IFID,
  output logic [1:0]      ALUSrcA_ByPassing,
  output logic [1:0]      ALUSrcB_ByPassing,
  output logic            Busy
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [1:0] CNT_INIT =
    (FLUSH_CYC > 0) ? 2'(FLUSH_CYC - 1) : 2'd0;

  state_t          state;
  logic [1:0]      cnt;

  logic [REGW-1:0] ex_rs, ex_rt, ex_dst;
  logic            ex_regwr, ex_load;
  logic [REGW-1:0] mem_dst;
  logic            mem_regwr, mem_load;
  logic [REGW-1:0] wr_dst;
  logic            wr_regwr;

  logic            hit_rs, hit_rt;
  logic            load_use, flushing;
  logic            unused_mem_load;

  assign unused_mem_load = mem_load;

  // MEM result wins over the older WR result
  function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] src);
    if (mem_regwr && mem_dst != '0 && mem_dst == src)
      return 2'b01;
    else if (wr_regwr && wr_dst != '0 && wr_dst == src)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  always_comb begin
    hit_rs   = UseRs_Id && (Rs_Id == ex_dst);
    hit_rt   = UseRt_Id && (Rt_Id == ex_dst);
    load_use = Valid_Id && ex_load && ex_regwr &&
               (ex_dst != '0) && (hit_rs || hit_rt);
    flushing = (state == FLUSH) || BrTaken_Ex;

    Stall_PC_IFID = Hold || (!flushing && load_use);
    Bubble_IDEX   = !Hold && (flushing || load_use);
    Flush_IFID    = flushing;
    Busy          = (state == FLUSH);

    ALUSrcA_ByPassing = fwd_sel(ex_rs);
    ALUSrcB_ByPassing = fwd_sel(ex_rt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_dst    <= '0;
      ex_regwr  <= 1'b0;
      ex_load   <= 1'b0;
      mem_dst   <= '0;
      mem_regwr <= 1'b0;
      mem_load  <= 1'b0;
      wr_dst    <= '0;
      wr_regwr  <= 1'b0;
      state     <= RUN;
      cnt       <= '0;
    end else if (!Hold) begin
      wr_dst    <= mem_dst;
      wr_regwr  <= mem_regwr;
      mem_dst   <= ex_dst;
      mem_regwr <= ex_regwr;
      mem_load  <= ex_load;
      if (Bubble_IDEX || !Valid_Id) begin
        ex_rs    <= '0;
        ex_rt    <= '0;
        ex_dst   <= '0;
        ex_regwr <= 1'b0;
        ex_load  <= 1'b0;
      end else begin
        ex_rs    <= Rs_Id;
        ex_rt    <= Rt_Id;
        ex_dst   <= Dst_Id;
        ex_regwr <= RegWr_Id;
        ex_load  <= MemToReg_Id;
      end
      unique case (state)
        RUN: begin
          if (BrTaken_Ex && FLUSH_CYC > 0) begin
            state <= FLUSH;
            cnt   <= CNT_INIT;
          end
        end
        FLUSH: begin
          if (cnt == '0) state <= RUN;
          else           cnt   <= cnt - 2'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: directed hazard scenarios
// followed by random traffic, checked against an instruction-level model.
module tb_hazard_fwd_ctrl;

  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst, Hold, Valid_Id;
  logic [4:0] Rs_Id, Rt_Id, Dst_Id;
  logic       UseRs_Id, UseRt_Id, RegWr_Id, MemToReg_Id, BrTaken_Ex;
  logic       Stall_PC_IFID, Bubble_IDEX, Flush_IFID, Busy;
  logic [1:0] ALUSrcA_ByPassing, ALUSrcB_ByPassing;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.FLUSH_CYC(FC), .REGW(5)) dut (
    .clk               (clk),
    .rst               (rst),
    .Hold              (Hold),
    .Valid_Id          (Valid_Id),
    .Rs_Id             (Rs_Id),
    .Rt_Id             (Rt_Id),
    .UseRs_Id          (UseRs_Id),
    .UseRt_Id          (UseRt_Id),
    .Dst_Id            (Dst_Id),
    .RegWr_Id          (RegWr_Id),
    .MemToReg_Id       (MemToReg_Id),
    .BrTaken_Ex        (BrTaken_Ex),
    .Stall_PC_IFID     (Stall_PC_IFID),
    .Bubble_IDEX       (Bubble_IDEX),
    .Flush_IFID        (Flush_IFID),
    .ALUSrcA_ByPassing (ALUSrcA_ByPassing),
    .ALUSrcB_ByPassing (ALUSrcB_ByPassing),
    .Busy              (Busy)
  );

  typedef struct packed {
    logic       rst, hold, valid;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] dst;
    logic       regwr, load, br;
  } stim_t;

  typedef struct packed {
    logic       stall, bubble, flush;
    logic [1:0] a, b;
    logic       busy;
  } out_t;

  typedef struct {
    logic [4:0] rs, rt, dst;
    bit         regwr, load;
  } ins_t;

  out_t  expq[$];
  string nameq[$];
  int    errors = 0;
  int    checks = 0;

  // model: instructions occupying EX, MEM, WR plus flush cycles left
  ins_t  m_ex, m_mem, m_wr, nop_ins;
  int    flush_left;

  function automatic logic [1:0] fwd(input logic [4:0] src);
    if (m_mem.regwr && m_mem.dst != 0 && m_mem.dst == src) return 2'b01;
    if (m_wr.regwr && m_wr.dst != 0 && m_wr.dst == src)   return 2'b10;
    return 2'b00;
  endfunction

  function automatic stim_t ins(input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt,
                                input logic [4:0] dst,
                                input logic regwr, input logic load);
    stim_t s;
    s = '0;
    s.valid = 1'b1;
    s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt;
    s.dst = dst; s.regwr = regwr; s.load = load;
    return s;
  endfunction

  task automatic step(input stim_t s, input string nm);
    out_t e;
    bit   lu, fl;
    @(posedge clk);
    #1;
    rst = s.rst; Hold = s.hold; Valid_Id = s.valid;
    Rs_Id = s.rs; Rt_Id = s.rt; UseRs_Id = s.urs; UseRt_Id = s.urt;
    Dst_Id = s.dst; RegWr_Id = s.regwr; MemToReg_Id = s.load;
    BrTaken_Ex = s.br;

    lu = s.valid && m_ex.load && m_ex.regwr && m_ex.dst != 0 &&
         ((s.urs && s.rs == m_ex.dst) || (s.urt && s.rt == m_ex.dst));
    fl = (flush_left > 0) || s.br;
    e.stall  = s.hold ? 1'b1 : (!fl && lu);
    e.bubble = s.hold ? 1'b0 : (fl || lu);
    e.flush  = fl;
    e.a      = fwd(m_ex.rs);
    e.b      = fwd(m_ex.rt);
    e.busy   = flush_left > 0;
    expq.push_back(e);
    nameq.push_back(nm);

    if (s.rst) begin
      m_ex = nop_ins; m_mem = nop_ins; m_wr = nop_ins;
      flush_left = 0;
    end else if (!s.hold) begin
      m_wr  = m_mem;
      m_mem = m_ex;
      if (e.bubble || !s.valid) m_ex = nop_ins;
      else m_ex = '{rs: s.rs, rt: s.rt, dst: s.dst,
                    regwr: s.regwr, load: s.load};
      if (flush_left > 0) flush_left--;
      else if (s.br)      flush_left = FC;
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      out_t  e, got;
      string nm;
      e  = expq.pop_front();
      nm = nameq.pop_front();
      got = {Stall_PC_IFID, Bubble_IDEX, Flush_IFID,
             ALUSrcA_ByPassing, ALUSrcB_ByPassing, Busy};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got %b required %b (stall,bubble,flush,a,b,busy)",
                 nm, got, e);
      end
    end
  end

  initial begin
    stim_t nop, s;
    nop_ins = '{rs: 0, rt: 0, dst: 0, regwr: 0, load: 0};
    m_ex = nop_ins; m_mem = nop_ins; m_wr = nop_ins;
    flush_left = 0;
    nop = '0;
    rst = 1'b1; Hold = 1'b0; Valid_Id = 1'b0;
    Rs_Id = '0; Rt_Id = '0; UseRs_Id = 1'b0; UseRt_Id = 1'b0;
    Dst_Id = '0; RegWr_Id = 1'b0; MemToReg_Id = 1'b0; BrTaken_Ex = 1'b0;
    @(posedge clk);
    step(nop, "reset_state");
    step(nop, "reset_idle");

    // add $3 ; sub $6,$3,$4  -> A=01
    step(ins(1, 2, 1, 1, 3, 1, 0), "a_add");
    step(ins(3, 4, 1, 1, 6, 1, 0), "a_sub_id");
    step(nop, "a_sub_ex_mem_fwd");
    step(nop, "a_tail");
    // add $3 ; unrelated ; sub -> A=10
    step(ins(1, 2, 1, 1, 3, 1, 0), "a2_add");
    step(ins(7, 8, 1, 1, 9, 1, 0), "a2_other");
    step(ins(3, 4, 1, 1, 6, 1, 0), "a2_sub_id");
    step(nop, "a2_sub_ex_wr_fwd");
    step(nop, "a2_tail");

    // $3 in both MEM and WR -> MEM priority
    step(ins(1, 1, 1, 1, 3, 1, 0), "b_add1");
    step(ins(2, 2, 1, 1, 3, 1, 0), "b_add2");
    step(ins(3, 3, 1, 1, 6, 1, 0), "b_sub_id");
    step(nop, "b_sub_ex");
    step(nop, "b_tail");

    // lw $5 ; add using rt=$5 -> stall one cycle, then WR forward
    step(ins(1, 0, 1, 0, 5, 1, 1), "c_lw");
    step(ins(2, 5, 1, 1, 7, 1, 0), "c_add_stall");
    step(ins(2, 5, 1, 1, 7, 1, 0), "c_add_retry");
    step(nop, "c_add_ex");
    step(nop, "c_tail");

    // taken branch: three flush cycles, two busy cycles
    s = nop; s.br = 1'b1;
    step(s, "d_br");
    step(nop, "d_flush1");
    step(nop, "d_flush2");
    step(nop, "d_run");
    step(nop, "d_run2");

    // load-use coincident with a taken branch
    step(ins(1, 0, 1, 0, 5, 1, 1), "e_lw");
    s = ins(5, 0, 1, 0, 7, 1, 0); s.br = 1'b1;
    step(s, "e_lu_br");
    step(nop, "e_flush1");
    step(nop, "e_flush2");
    step(nop, "e_tail");

    // hold for three cycles mid-flush
    step(ins(1, 2, 1, 1, 3, 1, 0), "f_pre");
    s = nop; s.br = 1'b1;
    step(s, "f_br");
    s = nop; s.hold = 1'b1;
    step(s, "f_hold1");
    step(s, "f_hold2");
    step(s, "f_hold3");
    step(nop, "f_flush1");
    step(ins(3, 3, 1, 1, 4, 1, 0), "f_flush2");
    step(nop, "f_run");
    // reset during flush
    s = nop; s.br = 1'b1;
    step(s, "f_br2");
    s = nop; s.rst = 1'b1; s.hold = 1'b1;
    step(s, "f_rst");
    step(nop, "f_after_rst");
    // writes to $0 never forward or stall
    step(ins(1, 2, 1, 1, 0, 1, 0), "f_zero_add");
    step(ins(0, 0, 1, 1, 0, 1, 1), "f_zero_lw");
    step(ins(0, 0, 1, 1, 4, 1, 0), "f_zero_use");
    step(nop, "f_zero_ex");
    step(nop, "f_zero_tail");

    for (int i = 0; i < 1500; i++) begin
      s = '0;
      s.rst   = ($urandom_range(99) < 2);
      s.hold  = ($urandom_range(99) < 15);
      s.valid = ($urandom_range(99) < 85);
      s.rs    = 5'($urandom_range(3));
      s.rt    = 5'($urandom_range(3));
      s.urs   = 1'($urandom_range(1));
      s.urt   = 1'($urandom_range(1));
      s.dst   = 5'($urandom_range(3));
      s.regwr = ($urandom_range(99) < 75);
      s.load  = ($urandom_range(99) < 35);
      s.br    = ($urandom_range(99) < 10);
      step(s, "random");
    end

    repeat (3) @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
